// File: rtl/mmix_mem_arbiter.sv
// Two-port round-robin arbiter sharing the MMIX memory bus between the
// instruction-fetch port (port 0) and the load/store port (port 1).
// One transfer is outstanding at a time; an optional watchdog completes
// transfers that never see mmix_done, flagging them with an error pulse.
module mmix_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] p0_address,
    input  logic [1:0]  p0_datasize,
    input  logic        p0_read,
    input  logic        p0_write,
    input  logic [63:0] p0_writedata,
    output logic [63:0] p0_readdata,
    output logic        p0_done,
    output logic        p0_err,
    input  logic [63:0] p1_address,
    input  logic [1:0]  p1_datasize,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [63:0] p1_writedata,
    output logic [63:0] p1_readdata,
    output logic        p1_done,
    output logic        p1_err,
    output logic [63:0] mmix_address,
    output logic [1:0]  mmix_datasize,
    output logic        mmix_read,
    output logic        mmix_write,
    output logic [63:0] mmix_writedata,
    input  logic [63:0] mmix_readdata,
    input  logic        mmix_done
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
    localparam logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    state_t      state;
    logic        last_grant;
    logic        grant;
    logic        err_flag;
    logic [31:0] wd_cnt;
    logic        p0_req;
    logic        p1_req;
    logic        win;
    logic        wd_expire;

    // Request decode and round-robin winner selection for the IDLE state.
    always_comb begin
        p0_req = p0_read | p0_write;
        p1_req = p1_read | p1_write;
        win    = last_grant;
        if (p0_req && p1_req) begin
            win = ~last_grant;
        end else if (p0_req) begin
            win = 1'b0;
        end else if (p1_req) begin
            win = 1'b1;
        end
    end

    // The counter value in the final allowed BUSY cycle is TIMEOUT_CYCLES-1.
    assign wd_expire = WD_EN && (wd_cnt == WD_LAST);

    // Error pulses ride on the done pulse of the port whose transfer timed out.
    assign p0_err = p0_done & err_flag;
    assign p1_err = p1_done & err_flag;

    // Arbitration FSM: capture winner, hold the bus until done or timeout, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant          <= 1'b0;
            err_flag       <= 1'b0;
            wd_cnt         <= '0;
            mmix_address   <= '0;
            mmix_datasize  <= '0;
            mmix_writedata <= '0;
            mmix_read      <= 1'b0;
            mmix_write     <= 1'b0;
            p0_readdata    <= '0;
            p1_readdata    <= '0;
            p0_done        <= 1'b0;
            p1_done        <= 1'b0;
        end else begin
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        grant          <= win;
                        last_grant     <= win;
                        err_flag       <= 1'b0;
                        wd_cnt         <= '0;
                        mmix_address   <= win ? p1_address   : p0_address;
                        mmix_datasize  <= win ? p1_datasize  : p0_datasize;
                        mmix_writedata <= win ? p1_writedata : p0_writedata;
                        // read+write together on one port counts as a write
                        mmix_write     <= win ? p1_write  : p0_write;
                        mmix_read      <= win ? ~p1_write : ~p0_write;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (mmix_done) begin
                        mmix_read  <= 1'b0;
                        mmix_write <= 1'b0;
                        if (mmix_read) begin
                            if (grant) p1_readdata <= mmix_readdata;
                            else       p0_readdata <= mmix_readdata;
                        end
                        p0_done <= ~grant;
                        p1_done <= grant;
                        state   <= RESP;
                    end else if (wd_expire) begin
                        mmix_read  <= 1'b0;
                        mmix_write <= 1'b0;
                        if (grant) p1_readdata <= ERR_DATA;
                        else       p0_readdata <= ERR_DATA;
                        err_flag <= 1'b1;
                        p0_done  <= ~grant;
                        p1_done  <= grant;
                        state    <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
